pmod_pos_link: RTL and testbench
================================

// Module: pmod_pos_link
// PURPOSE
//  Parametrised board-to-board link carrying a position word over Pmod pins.
//  - Next generation of the fixed 10-bit {JA,JB} -> {JBo,JC} position exchange.
//  - Carries a toggle strobe, heartbeat, settle filter and link-up status.
//  - Sits between the Pmod pins in the FPGA top and the game logic in top, on the 65 MHz pclk domain.
// PARAMETERS
//  DATA_W          10    position word width
//  STABLE_CYCLES   4     rx: cycles a synchronised frame must hold unchanged before accept (>=2)
//  HOLD_CYCLES     8     tx: min cycles a frame is held before the next load (> STABLE_CYCLES+2)
//  HB_CYCLES       1024  tx: idle cycles before the same data is re-sent (heartbeat)
//  TIMEOUT_CYCLES  4096  rx: cycles with no accepted frame before link_up drops (> HB_CYCLES+HOLD_CYCLES)
//  localparam PIN_W = DATA_W+1 (+1 if PMOD_LINK_PARITY_EN); bit DATA_W = toggle, top bit = parity
// PORTS
//  clk        in   1      pixel clock, 65 MHz
//  rst_n      in   1      asynchronous, active-low reset
//  tx_data    in   DATA_W word to send
//  tx_valid   in   1      load request; transfer on tx_valid & tx_ready
//  tx_ready   out  1      tx can accept a word
//  link_out   out  PIN_W  registered pin drive (to JBo/JC)
//  link_in    in   PIN_W  raw asynchronous pins (from JA/JB)
//  rx_data    out  DATA_W last accepted word
//  rx_valid   out  1      one-cycle pulse when rx_data updates
//  link_up    out  1      peer alive
//  err_cnt    out  8      saturating count of rejected frames (0 without PMOD_LINK_PARITY_EN)
// BEHAVIOUR
//  Clock/reset: single clk; rst_n asynchronous assert, all state async-cleared.
//  Reset values: link_out=0, tx_ready=0, rx_data=0, rx_valid=0, link_up=0, err_cnt=0; sync regs=0.
//  TX FSM: HOLD -> IDLE.
//   - Enters HOLD from reset; tx_ready=1 only in IDLE.
//   - In IDLE on tx_valid: register tx_data into link_out, invert toggle bit, recompute parity, enter HOLD.
//   - In IDLE with hb_cnt==HB_CYCLES-1: re-send current data with inverted toggle, enter HOLD.
//   - HOLD counts HOLD_CYCLES, then returns to IDLE.
//   - Data, toggle and parity change on the same clk edge.
//   - hb_cnt clears on every send.
//  RX path:
//   - 2-FF synchroniser on all PIN_W bits gives s_in.
//   - Compare register holds s_in of the previous cycle; stab_cnt clears when s_in differs, else increments.
//   - stab_cnt saturates at STABLE_CYCLES.
//  RX FSM: WAIT -> SETTLE -> WAIT.
//   - WAIT: enter SETTLE when s_in toggle != last accepted toggle.
//   - SETTLE, stab_cnt reaches STABLE_CYCLES-1:
//     - accept: rx_data<=s_in data, last toggle<=s_in toggle, rx_valid=1 for 1 cycle, back to WAIT.
//   - SETTLE, toggle reverts to last accepted value: back to WAIT, no accept.
//   - Latency: rx_valid rises STABLE_CYCLES+2 cycles after link_in is last changed.
//   - Heartbeat frames with identical data still pulse rx_valid.
//  Link status:
//   - to_cnt clears on accept and counts otherwise, saturating.
//   - link_up=1 from the first accept; link_up=0 when to_cnt==TIMEOUT_CYCLES-1.
//   - Accept and timeout in the same cycle: accept wins.
//  Reset mid-transfer:
//   - Both FSMs return to reset state; last accepted toggle=0.
//   - The first frame after reset is accepted only if its toggle is 1.
//   - The peer heartbeat guarantees a toggle=1 frame within 2*HB_CYCLES.
//  Arithmetic: counters are $clog2(max+1) bits wide; no wrap-around.
// CONFIGURATION
//  PMOD_LINK_PARITY_EN defined:
//   - Extra even-parity pin over data+toggle.
//   - RX checks parity at accept time.
//   - Bad frame: no rx_valid, rx_data unchanged, last toggle IS updated (no retry storm), err_cnt+1 saturating at 255.
//  Not defined: PIN_W = DATA_W+1, no check, err_cnt tied to 0.
// TESTING
//  - Loopback link_out->link_in. After reset: tx_valid with 10'h2A5 -> tx_ready low 8 cycles; rx_valid once, 6 cycles after pin change; rx_data=10'h2A5; link_up=1.
//  - Glitch: toggle flipped, data bit toggling every 2 cycles for 20 cycles, then stable 10'h155 -> single rx_valid 6 cycles after last change; rx_data=10'h155.
//  - Idle: no tx_valid for 3000 cycles -> heartbeats every 1032 cycles; rx_valid pulses with unchanged rx_data; link_up stays 1.
//  - Disconnect link_in (hold 0) after an accept -> link_up falls exactly 4096 cycles after the last accept; reconnect -> link_up=1 on the next heartbeat.
//  - rst_n low for 3 cycles mid-HOLD -> all outputs zero immediately (async); tx_ready returns 8 cycles after release.
//  - PMOD_LINK_PARITY_EN: flip parity pin on one frame -> no rx_valid, err_cnt=1; next good frame accepted normally.

Source files
------------

// File: rtl/pmod_pos_link.sv
// pmod_pos_link: toggle-strobed position-word link over Pmod pins with settle filter,
// heartbeat re-send and link-up status. Define PMOD_LINK_PARITY_EN to add an even-parity pin.
module pmod_pos_link #(
  parameter int DATA_W         = 10,
  parameter int STABLE_CYCLES  = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int HB_CYCLES      = 1024,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
`ifdef PMOD_LINK_PARITY_EN
  output logic [DATA_W+1:0] link_out,
  input  logic [DATA_W+1:0] link_in,
`else
  output logic [DATA_W:0]   link_out,
  input  logic [DATA_W:0]   link_in,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              link_up,
  output logic [7:0]        err_cnt
);

`ifdef PMOD_LINK_PARITY_EN
  localparam int PIN_W = DATA_W + 2;
`else
  localparam int PIN_W = DATA_W + 1;
`endif
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int HB_W   = $clog2(HB_CYCLES + 1);
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HB_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_ACC  = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

`ifdef PMOD_LINK_PARITY_EN
  function automatic logic even_par(input logic [DATA_W:0] frame);
    return ^frame;
  endfunction
`endif

  typedef enum logic {TX_HOLD = 1'b0, TX_IDLE = 1'b1} tx_state_e;
  typedef enum logic {RX_WAIT = 1'b0, RX_SETTLE = 1'b1} rx_state_e;

  tx_state_e         tx_state_q, tx_state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [HB_W-1:0]   hb_cnt_q, hb_cnt_d;
  logic [PIN_W-1:0]  link_out_q, link_out_d;
  logic              tx_ready_q, tx_ready_d;
  logic [DATA_W:0]   tx_frame_s;
  logic              send_s;

  // TX next-state: hold timer, load on request, heartbeat re-send with inverted toggle
  always_comb begin
    tx_state_d = tx_state_q;
    hold_cnt_d = hold_cnt_q;
    hb_cnt_d   = hb_cnt_q;
    tx_frame_s = link_out_q[DATA_W:0];
    send_s     = 1'b0;
    case (tx_state_q)
      TX_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          tx_state_d = TX_IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      TX_IDLE: begin
        if (tx_valid) begin
          send_s     = 1'b1;
          tx_frame_s = {~link_out_q[DATA_W], tx_data};
        end else if (hb_cnt_q == HB_LAST) begin
          send_s     = 1'b1;
          tx_frame_s = {~link_out_q[DATA_W], link_out_q[DATA_W-1:0]};
        end else begin
          hb_cnt_d = hb_cnt_q + HB_W'(1);
        end
        if (send_s) begin
          tx_state_d = TX_HOLD;
          hb_cnt_d   = '0;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: begin
        tx_state_d = TX_HOLD;
        hold_cnt_d = '0;
      end
    endcase
`ifdef PMOD_LINK_PARITY_EN
    link_out_d = {even_par(tx_frame_s), tx_frame_s};
`else
    link_out_d = tx_frame_s;
`endif
    tx_ready_d = (tx_state_d == TX_IDLE);
  end

  // TX state and pin register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_HOLD;
      hold_cnt_q <= '0;
      hb_cnt_q   <= '0;
      link_out_q <= '0;
      tx_ready_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      hold_cnt_q <= hold_cnt_d;
      hb_cnt_q   <= hb_cnt_d;
      link_out_q <= link_out_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  rx_state_e         rx_state_q, rx_state_d;
  logic [PIN_W-1:0]  sync1_q, s_in_q, prev_q;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              last_tog_q, last_tog_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              link_up_q, link_up_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              settle_done_s;
  logic              par_ok_s;
  logic              accept_s;

  // RX next-state: stability counter, settle FSM, accept and link timeout
  always_comb begin
    if (s_in_q != prev_q) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q == STAB_MAX) begin
      stab_cnt_d = stab_cnt_q;
    end else begin
      stab_cnt_d = stab_cnt_q + STAB_W'(1);
    end
`ifdef PMOD_LINK_PARITY_EN
    par_ok_s = (even_par(s_in_q[DATA_W:0]) == s_in_q[PIN_W-1]);
`else
    par_ok_s = 1'b1;
`endif
    rx_state_d    = rx_state_q;
    last_tog_d    = last_tog_q;
    settle_done_s = 1'b0;
    case (rx_state_q)
      RX_WAIT: begin
        if (s_in_q[DATA_W] != last_tog_q) begin
          rx_state_d = RX_SETTLE;
        end else begin
          rx_state_d = RX_WAIT;
        end
      end
      RX_SETTLE: begin
        // Looking at the next stab value lands rx_valid STABLE_CYCLES+2 after the pin edge
        if (s_in_q[DATA_W] == last_tog_q) begin
          rx_state_d = RX_WAIT;
        end else if (stab_cnt_d >= STAB_ACC) begin
          rx_state_d    = RX_WAIT;
          last_tog_d    = s_in_q[DATA_W];
          settle_done_s = 1'b1;
        end else begin
          rx_state_d = RX_SETTLE;
        end
      end
      default: begin
        rx_state_d = RX_WAIT;
      end
    endcase
    accept_s   = settle_done_s & par_ok_s;
    rx_valid_d = accept_s;
    if (accept_s) begin
      rx_data_d = s_in_q[DATA_W-1:0];
    end else begin
      rx_data_d = rx_data_q;
    end
    if (accept_s) begin
      to_cnt_d  = '0;
      link_up_d = 1'b1;
    end else if (to_cnt_q == TO_LAST) begin
      to_cnt_d  = to_cnt_q;
      link_up_d = 1'b0;
    end else begin
      to_cnt_d  = to_cnt_q + TO_W'(1);
      link_up_d = link_up_q;
    end
  end

  // RX synchroniser, compare register and receive state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      s_in_q     <= '0;
      prev_q     <= '0;
      stab_cnt_q <= '0;
      rx_state_q <= RX_WAIT;
      last_tog_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      link_up_q  <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      sync1_q    <= link_in;
      s_in_q     <= sync1_q;
      prev_q     <= s_in_q;
      stab_cnt_q <= stab_cnt_d;
      rx_state_q <= rx_state_d;
      last_tog_q <= last_tog_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      link_up_q  <= link_up_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

`ifdef PMOD_LINK_PARITY_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Bad-parity frames still consume their toggle so the peer does not retry forever
  always_comb begin
    if (settle_done_s && !par_ok_s && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'h01;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Rejected-frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

  assign tx_ready = tx_ready_q;
  assign link_out = link_out_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign link_up  = link_up_q;

endmodule

// File: tb/tb_pmod_pos_link.sv
// tb_pmod_pos_link: loopback scoreboard bench for pmod_pos_link; link_in can be taken
// over by the bench for glitch, parity and disconnect stimulus.
module tb_pmod_pos_link;
  localparam int DATA_W = 10;
`ifdef PMOD_LINK_PARITY_EN
  localparam int PIN_W = DATA_W + 2;
`else
  localparam int PIN_W = DATA_W + 1;
`endif
  localparam int LAT       = 6;
  localparam int HB_PERIOD = 1032;
  localparam int TIMEOUT   = 4096;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tx_valid = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_ready;
  logic [PIN_W-1:0]  link_out, link_in;
  logic [PIN_W-1:0]  tb_pins = '0;
  logic              tb_drive = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, link_up;
  logic [7:0]        err_cnt;

  assign link_in = tb_drive ? tb_pins : link_out;

  pmod_pos_link dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .link_out(link_out), .link_in(link_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .link_up(link_up), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                at;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int hb_seen = 0;
  int last_send_edge = 0;
  logic tx_tog = 1'b0;
  logic [DATA_W-1:0] last_sent = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [PIN_W-1:0] frame(input logic tog, input logic [DATA_W-1:0] d);
    logic [DATA_W:0] f;
    f = {tog, d};
`ifdef PMOD_LINK_PARITY_EN
    return {^f, f};
`else
    return f;
`endif
  endfunction

  // Toggle the transmitter shows after heartbeats since the last explicit send
  function automatic logic tog_now(input int c);
    return tx_tog ^ (((c - last_send_edge) / HB_PERIOD) % 2 == 1);
  endfunction

  // Scoreboard: queued frames must arrive on their cycle; anything else must be a heartbeat
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rx_valid) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("rx_data", 64'(rx_data), 64'(e.data));
        check_eq("rx_cycle", 64'(cyc), 64'(e.at));
      end else begin
        check_eq("hb_data", 64'(rx_data), 64'(last_sent));
        check_eq("hb_grid", 64'((cyc - LAT - last_send_edge) % HB_PERIOD), 64'(0));
        hb_seen++;
      end
    end
  end

  task automatic wait_ready();
    int w;
    w = 0;
    while (tx_ready !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (tx_ready !== 1'b1) check_eq("tx_ready_timeout", 64'(tx_ready), 64'(1));
  endtask

  task automatic drain(input int limit);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < limit) begin
      @(negedge clk);
      w++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input bit check_gap);
    exp_t e;
    int   h;
    wait_ready();
    tx_data        = d;
    tx_valid       = 1'b1;
    tx_tog         = ~tog_now(cyc);
    last_send_edge = cyc + 1;
    last_sent      = d;
    e.data = d;
    e.at   = cyc + 1 + LAT;
    exp_q.push_back(e);
    @(negedge clk);
    tx_valid = 1'b0;
    h = cyc;
    check_eq("link_out", 64'(link_out), 64'(frame(tx_tog, d)));
    if (check_gap) begin
      wait_ready();
      check_eq("tx_ready_gap", 64'(cyc - h), 64'(8));
    end
  endtask

  task automatic release_reset();
    int c0;
    @(negedge clk);
    rst_n          = 1'b1;
    c0             = cyc;
    last_send_edge = cyc;
    tx_tog         = 1'b0;
    last_sent      = '0;
    wait_ready();
    check_eq("ready_after_reset", 64'(cyc - c0), 64'(8));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_link_out"}, 64'(link_out), 64'(0));
    check_eq({tag, "_tx_ready"}, 64'(tx_ready), 64'(0));
    check_eq({tag, "_rx_data"}, 64'(rx_data), 64'(0));
    check_eq({tag, "_rx_valid"}, 64'(rx_valid), 64'(0));
    check_eq({tag, "_link_up"}, 64'(link_up), 64'(0));
    check_eq({tag, "_err_cnt"}, 64'(err_cnt), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   w;
    int   a_edge;
    int   h0;
    int   ev;
    logic g;
`ifdef PMOD_LINK_PARITY_EN
    logic [PIN_W-1:0] bad;
    logic             t;
`endif
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    release_reset();
    check_eq("link_up_before_accept", 64'(link_up), 64'(0));

    send(10'h2A5, 1'b1);
    drain(200);
    check_eq("rx_2a5", 64'(rx_data), 64'(10'h2A5));
    check_eq("link_up_first", 64'(link_up), 64'(1));
    send(10'h3FF, 1'b1);
    send(10'h000, 1'b1);
    send(10'h000, 1'b1);
    send(10'h1C3, 1'b1);
    drain(200);
    check_eq("rx_1c3", 64'(rx_data), 64'(10'h1C3));

    // glitchy frame: toggle flipped, data bit 0 bouncing every 2 cycles, then stable 155
    send(10'h0F3, 1'b1);
    drain(200);
    tb_pins  = frame(tx_tog, last_sent);
    tb_drive = 1'b1;
    g = ~tx_tog;
    for (int i = 0; i < 10; i++) begin
      tb_pins = frame(g, 10'h155 ^ DATA_W'(i % 2));
      repeat (2) @(negedge clk);
    end
    tb_pins = frame(g, 10'h155);
    e.data = 10'h155;
    e.at   = cyc + LAT;
    exp_q.push_back(e);
    repeat (12) @(negedge clk);
    drain(50);
    check_eq("glitch_rx", 64'(rx_data), 64'(10'h155));
    tb_drive = 1'b0;
    e.data = last_sent;
    e.at   = cyc + LAT;
    exp_q.push_back(e);
    drain(50);
    check_eq("reconnect_rx", 64'(rx_data), 64'(last_sent));

`ifdef PMOD_LINK_PARITY_EN
    send(10'h2D2, 1'b1);
    drain(200);
    t = tx_tog;
    tb_pins  = frame(t, last_sent);
    tb_drive = 1'b1;
    @(negedge clk);
    bad = frame(~t, 10'h3C3);
    bad[PIN_W-1] = ~bad[PIN_W-1];
    tb_pins = bad;
    repeat (12) @(negedge clk);
    check_eq("bad_parity_err_cnt", 64'(err_cnt), 64'(1));
    check_eq("bad_parity_rx_kept", 64'(rx_data), 64'(10'h2D2));
    tb_pins = frame(t, 10'h0F0);
    e.data = 10'h0F0;
    e.at   = cyc + LAT;
    exp_q.push_back(e);
    drain(50);
    check_eq("good_after_bad", 64'(rx_data), 64'(10'h0F0));
    check_eq("err_cnt_stays", 64'(err_cnt), 64'(1));
    tb_drive = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("same_toggle_no_accept", 64'(rx_data), 64'(10'h0F0));
`else
    check_eq("err_cnt_tied", 64'(err_cnt), 64'(0));
`endif

    // idle: two heartbeats expected within 3000 cycles of a send
    send(10'h19B, 1'b1);
    drain(200);
    h0 = hb_seen;
    repeat (3000) @(negedge clk);
    check_eq("hb_count", 64'(hb_seen - h0), 64'(2));
    check_eq("hb_link_up", 64'(link_up), 64'(1));
    check_eq("hb_rx_data", 64'(rx_data), 64'(10'h19B));

    // disconnect after an accept whose toggle is 0, so held-low pins look like no frame
    send(10'h2E7, 1'b1);
    drain(200);
    if (tx_tog) begin
      send(10'h2E7, 1'b1);
      drain(200);
    end
    a_edge = last_send_edge + LAT;
    tb_pins  = '0;
    tb_drive = 1'b1;
    w = 0;
    while (link_up !== 1'b0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check_eq("link_down_cycle", 64'(cyc - a_edge), 64'(TIMEOUT));
    w = 0;
    while (tog_now(cyc) != 1'b0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    tb_drive = 1'b0;
    ev = last_send_edge + HB_PERIOD * (((cyc - last_send_edge) / HB_PERIOD) + 1);
    e.data = last_sent;
    e.at   = ev + LAT;
    exp_q.push_back(e);
    drain(1200);
    check_eq("link_up_again", 64'(link_up), 64'(1));

    // reset in the middle of HOLD
    send(10'h0AA, 1'b0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    release_reset();
    send(10'h2A5, 1'b1);
    drain(200);
    check_eq("after_reset_rx", 64'(rx_data), 64'(10'h2A5));
    check_eq("after_reset_link_up", 64'(link_up), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
